tb_cmd_dispatcher: RTL and testbench
====================================

// Module: tb_cmd_dispatcher
// PURPOSE
//  Scheduler between the scenario sequencer and N testbench command targets (injectors, checkers, waiters).
//  Decodes args[0] keyword, routes the command to one target, waits for its done, then acks the sequencer
//  so the next line is fetched. Owns the sequencer ack, including the first post-reset kick, plus a WAIT builtin.
// PARAMETERS
//  ARGS_NB      5     string args per command line (matches sequencer)
//  N_TGT        4     number of command targets (1..16)
//  TIMEOUT_CYC  10000 watchdog limit in clk cycles per dispatched command (used only if DISP_TIMEOUT_EN)
// PORTS
//  clk             in   1         single clock; all logic on posedge
//  rst             in   1         synchronous reset, active-high
//  seq_args        in   string[ARGS_NB]  command fields from sequencer
//  seq_args_valid  in   1         one-cycle pulse: seq_args holds a new command
//  seq_ack         out  1         one-cycle pulse: sequencer may fetch next line
//  tgt_args        out  string[ARGS_NB]  registered copy of accepted command, broadcast to all targets
//  tgt_start       out  N_TGT     one-hot one-cycle start pulse to selected target
//  tgt_done        in   N_TGT     one-cycle completion pulse per target
//  busy            out  1         command in flight (DISPATCH/WAIT_DONE/WAIT_CNT)
//  cmd_unknown     out  1         sticky: unrecognised keyword seen
//  proto_err       out  1         sticky: seq_args_valid while busy, or done from non-selected target
//  timeout_err     out  1         sticky: watchdog expired (0 when DISP_TIMEOUT_EN undefined)
//  cmd_count       out  32        commands acked since reset, wraps at 2^32
// BEHAVIOUR
//  Reset: seq_ack=0, tgt_start=0, busy=0, all sticky flags=0, cmd_count=0, tgt_args all "", state=KICK.
//  FSM: KICK -> IDLE (seq_ack=1 for one cycle on KICK exit) ; IDLE waits seq_args_valid.
//  IDLE + valid: latch seq_args into tgt_args; decode args[0] against TGT_KEYWORDS[N_TGT]:
//   match k      -> DISPATCH: tgt_start[k]=1 next cycle exactly one cycle -> WAIT_DONE.
//   "WAIT"       -> $sscanf(args[1],"%d") into 32b counter; WAIT_CNT decrements each cycle; 0 -> ACK.
//                   n=0 or non-numeric -> ACK directly.
//   "NOP","END_TEST","" -> ACK directly (END_TEST forwarded to no target; sequencer terminates).
//   other        -> cmd_unknown=1, ACK.
//  WAIT_DONE: tgt_done[sel]=1 -> ACK. done on other bits -> proto_err=1, ignored.
//  ACK: seq_ack=1 for one cycle, cmd_count+=1 -> IDLE. Min latency valid->ack: 2 cycles (builtin), 4 (target w/ immediate done).
//  seq_args_valid outside IDLE: dropped, proto_err=1; no second ack generated.
//  tgt_done in same cycle as tgt_start: accepted (done counts).
//  Keyword compare exact, case-sensitive; first matching table entry wins.
//  Reset asserted mid-command: abort, state=KICK, in-flight target gets no further pulse; kick ack reissued.
// CONFIGURATION
//  DISP_TIMEOUT_EN defined: 32b watchdog cleared on DISPATCH, counts in WAIT_DONE/WAIT_CNT; reaching
//   TIMEOUT_CYC -> timeout_err=1, $display warning, go ACK. Done and expiry same cycle: done wins, no flag.
//   WAIT_CNT with n>TIMEOUT_CYC also times out.
//  Undefined: no watchdog logic, timeout_err tied 0, WAIT_DONE waits indefinitely.
// STRUCTURE
//  tb_disp_pkg: disp_state_e enum {KICK,IDLE,DISPATCH,WAIT_DONE,WAIT_CNT,ACK}; KW_WAIT/KW_NOP/KW_END
//   string constants; TGT_KEYWORDS default table {"SET_INJ","WTR","CHK","DATA_COLLECT"}; MAX_TGT=16.
//  Sub-module tb_disp_watchdog (clr, en, limit -> expired) instantiated only under DISP_TIMEOUT_EN.
// TESTING
//  Release rst after 5 cycles, no command -> exactly one seq_ack pulse 1 cycle after KICK, then idle.
//  Command "CHK A 1", tgt 2 done 7 cycles after start -> tgt_start=4'b0100 one cycle, seq_ack once, cmd_count=1.
//  "WAIT 20" -> seq_ack exactly 21-22 cycles after valid (document exact), no tgt_start; "WAIT 0" -> ack in 2.
//  "FOO X" -> cmd_unknown=1, ack in 2 cycles; then valid during WAIT_DONE of "WTR" -> proto_err=1, single ack.
//  DISP_TIMEOUT_EN, TIMEOUT_CYC=50, target never done -> timeout_err=1 at cycle 50, seq_ack follows; undefined: no ack.
//  rst pulse during WAIT_DONE -> flags/cmd_count cleared, new kick ack, following "SET_INJ" dispatched normally.

Source files
------------

// File: rtl/tb_disp_pkg.sv
// Shared types and constants for the testbench command dispatcher: FSM states,
// builtin keywords, the default target keyword table and a decimal argument parser.
package tb_disp_pkg;

    typedef enum logic [2:0] {
        KICK,
        IDLE,
        DISPATCH,
        WAIT_DONE,
        WAIT_CNT,
        ACK
    } disp_state_e;

    localparam int    MAX_TGT = 16;
    localparam int    SEL_W   = 4;
    localparam string KW_WAIT = "WAIT";
    localparam string KW_NOP  = "NOP";
    localparam string KW_END  = "END_TEST";

    // Default TGT_KEYWORDS table; entry k routes to tgt_start[k]. Empty entries never match.
    function automatic string tgt_keyword(input int k);
        case (k)
            0:       return "SET_INJ";
            1:       return "WTR";
            2:       return "CHK";
            3:       return "DATA_COLLECT";
            default: return "";
        endcase
    endfunction

    // Leading decimal digits of s; a string with no leading digit yields 0.
    function automatic logic [31:0] parse_dec(input string s);
        logic [31:0] acc;
        logic [7:0]  c;
        logic        stop;
        acc  = '0;
        stop = 1'b0;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (!stop && c >= 8'h30 && c <= 8'h39) begin
                acc = acc * 32'd10 + {24'd0, c - 8'h30};
            end else begin
                stop = 1'b1;
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/tb_disp_watchdog.sv
// Per-command watchdog: counts enabled cycles since the last clear and flags
// expiry on the cycle the count reaches the limit (used under DISP_TIMEOUT_EN).
module tb_disp_watchdog (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [31:0] limit_i,
    output logic        expired_o
);

    logic [31:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign expired_o = en_i && ((count_q + 32'd1) >= limit_i);

endmodule

// File: rtl/tb_cmd_dispatcher.sv
// Routes sequencer command lines to one of N_TGT targets or a builtin (WAIT/NOP/END_TEST),
// then acks the sequencer. Optional watchdog enabled by defining DISP_TIMEOUT_EN.
module tb_cmd_dispatcher
    import tb_disp_pkg::*;
#(
    parameter int ARGS_NB     = 5,
    parameter int N_TGT       = 4,
    parameter int TIMEOUT_CYC = 10000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  string             seq_args_i [ARGS_NB],
    input  logic              seq_args_valid_i,
    output logic              seq_ack_o,
    output string             tgt_args_o [ARGS_NB],
    output logic [N_TGT-1:0]  tgt_start_o,
    input  logic [N_TGT-1:0]  tgt_done_i,
    output logic              busy_o,
    output logic              cmd_unknown_o,
    output logic              proto_err_o,
    output logic              timeout_err_o,
    output logic [31:0]       cmd_count_o
);

    disp_state_e      state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d, hit_idx;
    logic [31:0]      wait_q, wait_d, wait_n, cmd_count_q;
    logic             seq_ack_q, ack_d, hit, cnt_inc, expired;
    logic             cmd_unknown_q, proto_err_q, timeout_err_q;
    logic             unknown_set, proto_set, timeout_set;
    logic [N_TGT-1:0] tgt_start_q, start_d, sel_mask;
    string            tgt_args_q [ARGS_NB];

`ifdef DISP_TIMEOUT_EN
    tb_disp_watchdog u_wdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (state_q == IDLE || state_q == DISPATCH),
        .en_i      (state_q == WAIT_DONE || state_q == WAIT_CNT),
        .limit_i   (32'(TIMEOUT_CYC)),
        .expired_o (expired)
    );
`else
    assign expired = 1'b0;
`endif

    // First matching table entry wins
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = 0; k < N_TGT; k++) begin
            if (!hit && tgt_keyword(k) != "" && seq_args_i[0] == tgt_keyword(k)) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(k);
            end
        end
        wait_n = parse_dec(seq_args_i[1]);
        for (int k = 0; k < N_TGT; k++) begin
            sel_mask[k] = (sel_q == SEL_W'(k));
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        wait_d      = wait_q;
        ack_d       = 1'b0;
        start_d     = '0;
        cnt_inc     = 1'b0;
        unknown_set = 1'b0;
        timeout_set = 1'b0;
        proto_set   = seq_args_valid_i && (state_q != IDLE);
        case (state_q)
            KICK: begin
                ack_d   = 1'b1;
                state_d = IDLE;
            end
            IDLE: begin
                if (seq_args_valid_i) begin
                    if (hit) begin
                        sel_d   = hit_idx;
                        state_d = DISPATCH;
                    end else if (seq_args_i[0] == KW_WAIT) begin
                        wait_d  = wait_n;
                        state_d = (wait_n == 32'd0) ? ACK : WAIT_CNT;
                    end else if (seq_args_i[0] == KW_NOP || seq_args_i[0] == KW_END
                                 || seq_args_i[0] == "") begin
                        state_d = ACK;
                    end else begin
                        unknown_set = 1'b1;
                        state_d     = ACK;
                    end
                end
            end
            DISPATCH: begin
                start_d = sel_mask;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                proto_set = proto_set || (|(tgt_done_i & ~sel_mask));
                if (|(tgt_done_i & sel_mask)) begin
                    state_d = ACK;
                end else if (expired) begin
                    timeout_set = 1'b1;
                    state_d     = ACK;
                end
            end
            WAIT_CNT: begin
                wait_d = wait_q - 32'd1;
                if (wait_q <= 32'd1) begin
                    state_d = ACK;
                end else if (expired) begin
                    timeout_set = 1'b1;
                    state_d     = ACK;
                end
            end
            ACK: begin
                ack_d   = 1'b1;
                cnt_inc = 1'b1;
                state_d = IDLE;
            end
            default: state_d = KICK;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= KICK;
            sel_q         <= '0;
            wait_q        <= '0;
            seq_ack_q     <= 1'b0;
            tgt_start_q   <= '0;
            cmd_unknown_q <= 1'b0;
            proto_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            cmd_count_q   <= '0;
            for (int i = 0; i < ARGS_NB; i++) tgt_args_q[i] <= "";
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            wait_q      <= wait_d;
            seq_ack_q   <= ack_d;
            tgt_start_q <= start_d;
            if (unknown_set) cmd_unknown_q <= 1'b1;
            if (proto_set)   proto_err_q   <= 1'b1;
            if (timeout_set) timeout_err_q <= 1'b1;
            if (cnt_inc)     cmd_count_q   <= cmd_count_q + 32'd1;
            if (state_q == IDLE && seq_args_valid_i) begin
                for (int i = 0; i < ARGS_NB; i++) tgt_args_q[i] <= seq_args_i[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < ARGS_NB; i++) tgt_args_o[i] = tgt_args_q[i];
    end

    assign seq_ack_o     = seq_ack_q;
    assign tgt_start_o   = tgt_start_q;
    assign busy_o        = (state_q == DISPATCH) || (state_q == WAIT_DONE) || (state_q == WAIT_CNT);
    assign cmd_unknown_o = cmd_unknown_q;
    assign proto_err_o   = proto_err_q;
    assign timeout_err_o = timeout_err_q;
    assign cmd_count_o   = cmd_count_q;

endmodule

// File: tb/tb_tb_cmd_dispatcher.sv
// Scoreboard bench for tb_cmd_dispatcher: expected ack cycles and start pulses are
// queued when commands are sent and matched by a negedge monitor.
module tb_tb_cmd_dispatcher;

    localparam int ARGS_NB     = 5;
    localparam int N_TGT       = 4;
    localparam int TIMEOUT_CYC = 50;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    string             seq_args [ARGS_NB];
    logic              valid = 1'b0;
    logic              ack;
    string             tgt_args [ARGS_NB];
    logic [N_TGT-1:0]  start;
    logic [N_TGT-1:0]  done = '0;
    logic              busy, unk, proto, tmo;
    logic [31:0]       cnt;

    int                n_chk  = 0;
    int                n_pass = 0;
    int                cyc    = 0;
    int                sb_ack [$];
    int                sb_st_cyc [$];
    logic [N_TGT-1:0]  sb_st_val [$];
    int                e_cyc;
    logic [N_TGT-1:0]  e_val;

    tb_cmd_dispatcher #(
        .ARGS_NB     (ARGS_NB),
        .N_TGT       (N_TGT),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .seq_args_i       (seq_args),
        .seq_args_valid_i (valid),
        .seq_ack_o        (ack),
        .tgt_args_o       (tgt_args),
        .tgt_start_o      (start),
        .tgt_done_i       (done),
        .busy_o           (busy),
        .cmd_unknown_o    (unk),
        .proto_err_o      (proto),
        .timeout_err_o    (tmo),
        .cmd_count_o      (cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every ack and every start pulse must match the head of its queue
    always @(negedge clk) begin
        if (ack === 1'b1) begin
            n_chk++;
            if (sb_ack.size() == 0) begin
                $display("FAIL ack_unexpected: seq_ack at cycle %0d, required none", cyc);
            end else begin
                e_cyc = sb_ack.pop_front();
                if (cyc !== e_cyc) $display("FAIL ack_cycle: got cycle %0d want %0d", cyc, e_cyc);
                else n_pass++;
            end
        end
        if (start !== '0) begin
            n_chk++;
            if (sb_st_cyc.size() == 0) begin
                $display("FAIL start_unexpected: tgt_start %b at cycle %0d, required none", start, cyc);
            end else begin
                e_cyc = sb_st_cyc.pop_front();
                e_val = sb_st_val.pop_front();
                if (cyc !== e_cyc || start !== e_val)
                    $display("FAIL start: got %b at %0d want %b at %0d", start, cyc, e_val, e_cyc);
                else n_pass++;
            end
        end
    end

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic send(input string a0, input string a1, input string a2);
        seq_args[0] = a0;
        seq_args[1] = a1;
        seq_args[2] = a2;
        seq_args[3] = "";
        seq_args[4] = "";
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic test_reset();
        int r;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        n_chk++; if (ack !== 1'b0)     $display("FAIL rst_ack: got %b want 0", ack); else n_pass++;
        n_chk++; if (start !== '0)     $display("FAIL rst_start: got %b want 0", start); else n_pass++;
        n_chk++; if (busy !== 1'b0)    $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        n_chk++; if ({unk, proto, tmo} !== 3'b000)
            $display("FAIL rst_flags: got %b want 000", {unk, proto, tmo}); else n_pass++;
        n_chk++; if (cnt !== 32'd0)    $display("FAIL rst_count: got %0d want 0", cnt); else n_pass++;
        n_chk++; if (tgt_args[0] != "") $display("FAIL rst_args: got '%s' want ''", tgt_args[0]); else n_pass++;
        r = cyc;
        sb_ack.push_back(r + 1);
        rst = 1'b0;
        wait_to(r + 8);
        n_chk++; if (sb_ack.size() != 0) $display("FAIL kick_ack: got %0d pending want 0", sb_ack.size()); else n_pass++;
        n_chk++; if (cnt !== 32'd0)    $display("FAIL kick_count: got %0d want 0", cnt); else n_pass++;
    endtask

    task automatic test_chk();
        int c0;
        c0 = cyc;
        sb_st_cyc.push_back(c0 + 2);
        sb_st_val.push_back(4'b0100);
        sb_ack.push_back(c0 + 11);
        send("CHK", "A", "1");
        wait_to(c0 + 5);
        n_chk++; if (busy !== 1'b1) $display("FAIL chk_busy: got %b want 1", busy); else n_pass++;
        n_chk++; if (tgt_args[0] != "CHK" || tgt_args[2] != "1")
            $display("FAIL chk_args: got '%s' '%s' want 'CHK' '1'", tgt_args[0], tgt_args[2]); else n_pass++;
        wait_to(c0 + 9);
        done = 4'b0100;
        @(negedge clk);
        done = '0;
        wait_to(c0 + 14);
        n_chk++; if (cnt !== 32'd1) $display("FAIL chk_count: got %0d want 1", cnt); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL chk_idle: got %b want 0", busy); else n_pass++;
        n_chk++; if (sb_ack.size() + sb_st_cyc.size() != 0)
            $display("FAIL chk_pending: got %0d want 0", sb_ack.size() + sb_st_cyc.size()); else n_pass++;
    endtask

    task automatic test_wait();
        int c0;
        string kw [5];
        string a1 [5];
        c0 = cyc;
        sb_ack.push_back(c0 + 22);
        send("WAIT", "20", "");
        wait_to(c0 + 10);
        n_chk++; if (busy !== 1'b1) $display("FAIL wait_busy: got %b want 1", busy); else n_pass++;
        wait_to(c0 + 25);
        n_chk++; if (cnt !== 32'd2) $display("FAIL wait_count: got %0d want 2", cnt); else n_pass++;
        kw[0] = "WAIT"; kw[1] = "NOP"; kw[2] = "END_TEST"; kw[3] = ""; kw[4] = "WAIT";
        a1[0] = "0";    a1[1] = "x";   a1[2] = "";         a1[3] = ""; a1[4] = "abc";
        for (int i = 0; i < 5; i++) begin
            c0 = cyc;
            sb_ack.push_back(c0 + 2);
            send(kw[i], a1[i], "");
            wait_to(c0 + 4);
            n_chk++; if (sb_ack.size() != 0)
                $display("FAIL builtin_ack_%0d: got %0d pending want 0", i, sb_ack.size()); else n_pass++;
        end
        n_chk++; if (cnt !== 32'd7) $display("FAIL builtin_count: got %0d want 7", cnt); else n_pass++;
        n_chk++; if (unk !== 1'b0)  $display("FAIL builtin_unknown: got %b want 0", unk); else n_pass++;
    endtask

    task automatic test_unknown();
        int c0;
        c0 = cyc;
        sb_ack.push_back(c0 + 2);
        send("FOO", "X", "");
        wait_to(c0 + 4);
        n_chk++; if (unk !== 1'b1) $display("FAIL unk_flag: got %b want 1", unk); else n_pass++;
        n_chk++; if (cnt !== 32'd8) $display("FAIL unk_count: got %0d want 8", cnt); else n_pass++;
        c0 = cyc;
        sb_ack.push_back(c0 + 2);
        send("chk", "A", "");
        wait_to(c0 + 4);
        n_chk++; if (cnt !== 32'd9) $display("FAIL case_count: got %0d want 9", cnt); else n_pass++;
    endtask

    task automatic test_proto();
        int c0;
        c0 = cyc;
        sb_st_cyc.push_back(c0 + 2);
        sb_st_val.push_back(4'b0010);
        sb_ack.push_back(c0 + 9);
        send("WTR", "a", "");
        wait_to(c0 + 4);
        send("NOP", "", "");
        wait_to(c0 + 6);
        n_chk++; if (proto !== 1'b1) $display("FAIL proto_flag: got %b want 1", proto); else n_pass++;
        n_chk++; if (busy !== 1'b1)  $display("FAIL proto_busy: got %b want 1", busy); else n_pass++;
        n_chk++; if (tgt_args[0] != "WTR") $display("FAIL proto_args: got '%s' want 'WTR'", tgt_args[0]); else n_pass++;
        wait_to(c0 + 7);
        done = 4'b0010;
        @(negedge clk);
        done = '0;
        wait_to(c0 + 14);
        n_chk++; if (cnt !== 32'd10) $display("FAIL proto_count: got %0d want 10", cnt); else n_pass++;
        n_chk++; if (sb_ack.size() != 0) $display("FAIL proto_pending: got %0d want 0", sb_ack.size()); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int c0;
        c0 = cyc;
        sb_st_cyc.push_back(c0 + 2);
        sb_st_val.push_back(4'b0010);
        send("WTR", "b", "");
        wait_to(c0 + 5);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++; if ({unk, proto, tmo} !== 3'b000)
            $display("FAIL mid_flags: got %b want 000", {unk, proto, tmo}); else n_pass++;
        n_chk++; if (cnt !== 32'd0)  $display("FAIL mid_count: got %0d want 0", cnt); else n_pass++;
        n_chk++; if (busy !== 1'b0)  $display("FAIL mid_busy: got %b want 0", busy); else n_pass++;
        sb_ack.push_back(cyc + 1);
        rst = 1'b0;
        wait_to(cyc + 3);
        c0 = cyc;
        sb_st_cyc.push_back(c0 + 2);
        sb_st_val.push_back(4'b0001);
        sb_ack.push_back(c0 + 4);
        send("SET_INJ", "1", "");
        wait_to(c0 + 2);
        done = 4'b0001;
        @(negedge clk);
        done = '0;
        wait_to(c0 + 6);
        n_chk++; if (cnt !== 32'd1)  $display("FAIL inj_count: got %0d want 1", cnt); else n_pass++;
        n_chk++; if (proto !== 1'b0) $display("FAIL inj_proto: got %b want 0", proto); else n_pass++;
        c0 = cyc;
        sb_st_cyc.push_back(c0 + 2);
        sb_st_val.push_back(4'b0001);
        sb_ack.push_back(c0 + 4);
        send("SET_INJ", "2", "");
        wait_to(c0 + 2);
        done = 4'b0011;
        @(negedge clk);
        done = '0;
        wait_to(c0 + 6);
        n_chk++; if (proto !== 1'b1) $display("FAIL wrong_done_proto: got %b want 1", proto); else n_pass++;
        n_chk++; if (cnt !== 32'd2)  $display("FAIL wrong_done_count: got %0d want 2", cnt); else n_pass++;
    endtask

    task automatic test_hang();
        int c0;
        c0 = cyc;
        sb_st_cyc.push_back(c0 + 2);
        sb_st_val.push_back(4'b1000);
`ifdef DISP_TIMEOUT_EN
        sb_ack.push_back(c0 + 53);
`endif
        send("DATA_COLLECT", "", "");
        wait_to(c0 + 45);
        n_chk++; if (busy !== 1'b1) $display("FAIL hang_busy: got %b want 1", busy); else n_pass++;
        n_chk++; if (tmo !== 1'b0)  $display("FAIL hang_early_tmo: got %b want 0", tmo); else n_pass++;
        wait_to(c0 + 60);
`ifdef DISP_TIMEOUT_EN
        n_chk++; if (tmo !== 1'b1)  $display("FAIL tmo_flag: got %b want 1", tmo); else n_pass++;
        n_chk++; if (cnt !== 32'd3) $display("FAIL tmo_count: got %0d want 3", cnt); else n_pass++;
`else
        n_chk++; if (busy !== 1'b1) $display("FAIL hang_still_busy: got %b want 1", busy); else n_pass++;
        n_chk++; if (cnt !== 32'd2) $display("FAIL hang_count: got %0d want 2", cnt); else n_pass++;
`endif
    endtask

    initial begin
        for (int i = 0; i < ARGS_NB; i++) seq_args[i] = "";
        test_reset();
        test_chk();
        test_wait();
        test_unknown();
        test_proto();
        test_reset_mid();
        test_hang();
        n_chk++; if (sb_ack.size() + sb_st_cyc.size() != 0)
            $display("FAIL final_pending: got %0d want 0", sb_ack.size() + sb_st_cyc.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
